// File: rtl/sram_mem_controller.sv
// MEM-stage data memory sequencer: splits each 32-bit load/store into two
// 16-bit transfers on an external asynchronous SRAM, stalling via ready.
module sram_mem_controller #(
  parameter int WAIT_STATES = 2,
  parameter int SRAM_ADDR_W = 18,
  parameter int DATA_BASE   = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic                   rd_en,
  input  logic [31:0]            address,
  input  logic [31:0]            write_data,
  output logic [31:0]            read_data,
  output logic                   ready,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [15:0]            sram_dq_out,
  output logic                   sram_dq_oe,
  input  logic [15:0]            sram_dq_in,
  output logic                   sram_we_n
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [3:0] LAST_CNT = 4'(WAIT_STATES);

  state_t                 state_r;
  logic [3:0]             cnt_r;
  logic                   is_wr_r;
  logic [SRAM_ADDR_W-1:0] hb_r;
  logic [31:0]            wdata_r;

  logic [31:0]            offset_s;
  logic [SRAM_ADDR_W-1:0] hb_s;
  logic                   phase_end_s;
  logic                   we_next_n_s;

  // Address mapping, phase-end detect and next-cycle strobe level
  always_comb begin
    offset_s    = address - 32'(DATA_BASE);
    // (offset >> 2) << 1 is the word index with a zero half-select bit; the
    // cast truncates it so out-of-range addresses wrap.
    hb_s        = SRAM_ADDR_W'((offset_s >> 2) << 1);
    phase_end_s = (cnt_r == LAST_CNT);
    // The strobe rises in the last cycle of a phase so data is stable at the edge
    if (is_wr_r) begin
      we_next_n_s = ((cnt_r + 4'd1) == LAST_CNT);
    end else begin
      we_next_n_s = 1'b1;
    end
  end

  // Pipeline stall: busy from the first cycle a request appears until DONE
  always_comb begin
    if (state_r == DONE) begin
      ready = 1'b1;
    end else if ((state_r == IDLE) && !wr_en && !rd_en) begin
      ready = 1'b1;
    end else begin
      ready = 1'b0;
    end
  end

  // Sequencer FSM; SRAM pins are set one edge ahead so they are registered
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= 4'd0;
      is_wr_r     <= 1'b0;
      hb_r        <= '0;
      wdata_r     <= 32'd0;
      read_data   <= 32'd0;
      sram_addr   <= '0;
      sram_dq_out <= 16'd0;
      sram_dq_oe  <= 1'b0;
      sram_we_n   <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          if (wr_en || rd_en) begin
            state_r     <= LOW;
            cnt_r       <= 4'd0;
            is_wr_r     <= wr_en;
            hb_r        <= hb_s;
            wdata_r     <= write_data;
            sram_addr   <= hb_s;
            sram_dq_out <= write_data[15:0];
            sram_dq_oe  <= wr_en;
            sram_we_n   <= ~wr_en;
          end
        end
        LOW: begin
          if (phase_end_s) begin
            state_r     <= HIGH;
            cnt_r       <= 4'd0;
            sram_addr   <= hb_r + SRAM_ADDR_W'(1);
            sram_dq_out <= wdata_r[31:16];
            sram_we_n   <= ~is_wr_r;
            if (!is_wr_r) begin
              read_data[15:0] <= sram_dq_in;
            end
          end else begin
            cnt_r     <= cnt_r + 4'd1;
            sram_we_n <= we_next_n_s;
          end
        end
        HIGH: begin
          if (phase_end_s) begin
            state_r    <= DONE;
            cnt_r      <= 4'd0;
            sram_we_n  <= 1'b1;
            sram_dq_oe <= 1'b0;
            if (!is_wr_r) begin
              read_data[31:16] <= sram_dq_in;
            end
          end else begin
            cnt_r     <= cnt_r + 4'd1;
            sram_we_n <= we_next_n_s;
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r    <= IDLE;
          cnt_r      <= 4'd0;
          sram_we_n  <= 1'b1;
          sram_dq_oe <= 1'b0;
        end
      endcase
    end
  end

endmodule
